// File: rtl/ex_alu_issue_pkg.sv
// Shared definitions for the EX-stage ALU issue/retire wrapper:
// ALU opcode encodings and default datapath widths.
package ex_alu_issue_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;
   localparam int PC_W       = 32;
   localparam int SHAMT_W    = 5;
   localparam int OP_W       = 4;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] ALU_ADDU = 4'b0001;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'b0010;
   localparam logic [OP_W-1:0] ALU_SUBU = 4'b0011;
   localparam logic [OP_W-1:0] ALU_AND  = 4'b0100;
   localparam logic [OP_W-1:0] ALU_OR   = 4'b0101;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'b0110;
   localparam logic [OP_W-1:0] ALU_NOR  = 4'b0111;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'b1010;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'b1011;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'b1100;
   localparam logic [OP_W-1:0] ALU_SLLV = 4'b1101;
   localparam logic [OP_W-1:0] ALU_SRLV = 4'b1110;
   localparam logic [OP_W-1:0] ALU_SRAV = 4'b1111;

   // Only the signed add/sub forms may raise an integer-overflow exception.
   function automatic logic is_trap_op(input logic [OP_W-1:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/ex_pipe_slot.sv
// Single valid/ready pipeline register with a kill input; clears payload
// only on reset so downstream consumers see stable data while idle.
module ex_pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // A killed cycle never accepts, so nothing slips in behind a flush.
   assign o_ready = ~reset & ~i_flush & (~r_valid | i_ready);
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_valid & o_ready) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_alu_issue.sv
// EX-stage issue/retire wrapper around an external combinational ALU.
// Build option: define EX_OV_TRAP_EN to trap signed add/sub overflow.
module ex_alu_issue
   import ex_alu_issue_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [OP_W-1:0]     id_alu_op,
   input  logic [DATA_W-1:0]   id_src_a,
   input  logic [DATA_W-1:0]   id_src_b,
   input  logic [SHAMT_W-1:0]  id_shamt,
   input  logic [REG_AW-1:0]   id_dest,
   input  logic [PC_W-1:0]     id_pc,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_op,
   output logic [SHAMT_W-1:0]  alu_shift,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic                alu_overflow,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [DATA_W-1:0]   ex_result,
   output logic [REG_AW-1:0]   ex_dest,
   output logic [PC_W-1:0]     ex_pc,
   output logic                ex_excp_ov
);

   localparam int S1_W = OP_W + SHAMT_W + 2*DATA_W + REG_AW + PC_W;
   localparam int S2_W = DATA_W + REG_AW + PC_W + 1;

   logic [S1_W-1:0]    w_s1_in;
   logic [S1_W-1:0]    w_s1_q;
   logic               w_s1_valid;
   logic [S2_W-1:0]    w_s2_in;
   logic [S2_W-1:0]    w_s2_q;
   logic               w_s2_in_ready;

   logic [OP_W-1:0]    w_op;
   logic [SHAMT_W-1:0] w_shamt;
   logic [DATA_W-1:0]  w_a;
   logic [DATA_W-1:0]  w_b;
   logic [REG_AW-1:0]  w_dest;
   logic [PC_W-1:0]    w_pc;
   logic               w_trap;
   logic [REG_AW-1:0]  w_ret_dest;

   assign w_s1_in = {id_alu_op, id_shamt, id_src_a, id_src_b, id_dest, id_pc};
   assign {w_op, w_shamt, w_a, w_b, w_dest, w_pc} = w_s1_q;

   ex_pipe_slot #(.W(S1_W)) u_s1 (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_valid (id_valid),
      .o_ready (id_ready),
      .i_data  (w_s1_in),
      .o_valid (w_s1_valid),
      .i_ready (w_s2_in_ready),
      .o_data  (w_s1_q)
   );

   // ALU sees the issue register only, so it holds the last op when idle.
   assign alu_a     = w_a;
   assign alu_b     = w_b;
   assign alu_op    = w_op;
   assign alu_shift = w_shamt;

`ifdef EX_OV_TRAP_EN
   assign w_trap = alu_overflow & is_trap_op(w_op);
`else
   logic w_unused_ov;
   assign w_unused_ov = alu_overflow;
   assign w_trap      = 1'b0;
`endif

   // A trapped op must not write back, so its destination is squashed to r0.
   assign w_ret_dest = w_trap ? '0 : w_dest;
   assign w_s2_in    = {alu_out, w_ret_dest, w_pc, w_trap};

   ex_pipe_slot #(.W(S2_W)) u_s2 (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_valid (w_s1_valid),
      .o_ready (w_s2_in_ready),
      .i_data  (w_s2_in),
      .o_valid (ex_valid),
      .i_ready (ex_ready),
      .o_data  (w_s2_q)
   );

   assign {ex_result, ex_dest, ex_pc, ex_excp_ov} = w_s2_q;

endmodule
